wb_stream_packer: RTL and testbench

Output packer directly downstream of the conv write-back controller. Takes the controller's two result lanes (`out_port0/1` with valids) and its `end_op` pulse, sign-extends each 25-bit result to 32 bits, and packs pairs in arrival order into 64-bit words. Words leave through a valid/ready stream toward the DMA/AXI writer, with `last` on the final word of a frame. The block drives the controller's `stall` input whenever it cannot absorb a cycle of results.

---
 rtl/wb_stream_packer.sv | 225 ++++++++++++++++++++++
 tb/tb_wb_stream_packer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_packer.sv
// wb_stream_packer: packs pairs of sign-extended write-back results into
// 2*LANE_WIDTH-bit words and streams them out through a first-word
// fall-through FIFO, with frame delimiting (m_last / frame_done).
// Optional feature macro: WB_PACK_ELEM_CNT_EN adds the frame_elems counter.
module wb_stream_packer #(
  parameter int DATA_WIDTH = 25,
  parameter int LANE_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_data0,
  input  logic                    in_valid0,
  input  logic [DATA_WIDTH-1:0]   in_data1,
  input  logic                    in_valid1,
  input  logic                    end_op,
  output logic                    stall,
  output logic [2*LANE_WIDTH-1:0] m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
`ifdef WB_PACK_ELEM_CNT_EN
  output logic [31:0]             frame_elems,
`endif
  output logic                    frame_done,
  output logic                    busy
);

  localparam int WW = 2 * LANE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  // Sign-extend one result element to a packed lane.
  function automatic logic [LANE_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] d);
    return LANE_WIDTH'($signed(d));
  endfunction

  state_t                state, state_n;
  logic [LANE_WIDTH-1:0] h, h_n;
  logic                  h_v, h_v_n;
  logic [WW-1:0]         s, s_n;
  logic                  s_v, s_v_n;
  logic [WW:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, accept, pop, push;
  logic [WW-1:0]         push_word;
  logic                  push_last;
  logic [WW-1:0]         word;
  logic                  word_form;
  logic [LANE_WIDTH-1:0] e0, e1;
  logic                  two, one;

  assign full   = (count == CW'(FIFO_DEPTH));
  assign stall  = (state != RUN) | full;
  assign accept = !stall;
  assign pop    = m_valid & m_ready;

  assign m_valid    = (count != {CW{1'b0}});
  assign m_data     = m_valid ? mem[rd_ptr][WW-1:0] : {WW{1'b0}};
  assign m_last     = m_valid ? mem[rd_ptr][WW] : 1'b0;
  assign frame_done = (state == DONE);
  assign busy       = (state != RUN) | m_valid | h_v | s_v;

  // Element selection: lane1 alone is treated as a single element.
  assign two = in_valid0 & in_valid1;
  assign one = in_valid0 ^ in_valid1;
  assign e0  = in_valid0 ? sext(in_data0) : sext(in_data1);
  assign e1  = sext(in_data1);

  // Pairing, word placement, flush sequencing and next-state decode.
  always_comb begin
    state_n   = state;
    h_n       = h;
    h_v_n     = h_v;
    s_n       = s;
    s_v_n     = s_v;
    push      = 1'b0;
    push_word = {WW{1'b0}};
    push_last = 1'b0;
    word      = {WW{1'b0}};
    word_form = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          if (h_v && two) begin
            word      = {e0, h};
            h_n       = e1;
            word_form = 1'b1;
          end else if (h_v && one) begin
            word      = {e0, h};
            h_v_n     = 1'b0;
            word_form = 1'b1;
          end else if (!h_v && two) begin
            word      = {e1, e0};
            word_form = 1'b1;
          end else if (!h_v && one) begin
            h_n   = e0;
            h_v_n = 1'b1;
          end else begin
            word_form = 1'b0;
          end
          if (word_form) begin
            // A newer word displaces the staged one into the FIFO; it is
            // never the frame's last word because S is refilled.
            if (s_v) begin
              push      = 1'b1;
              push_word = s;
              push_last = 1'b0;
            end else begin
              push = 1'b0;
            end
            s_n   = word;
            s_v_n = 1'b1;
          end else begin
            s_n = s;
          end
          if (end_op) begin
            if (!s_v_n && !h_v_n && (count == {CW{1'b0}})) begin
              state_n = DONE;
            end else begin
              state_n = FLUSH;
            end
          end else begin
            state_n = RUN;
          end
        end else begin
          state_n = RUN;
        end
      end
      FLUSH: begin
        if (s_v) begin
          if (!full) begin
            push      = 1'b1;
            push_word = s;
            push_last = !h_v;
            s_v_n     = 1'b0;
            state_n   = h_v ? FLUSH : DRAIN;
          end else begin
            state_n = FLUSH;
          end
        end else if (h_v) begin
          if (!full) begin
            push      = 1'b1;
            push_word = {{LANE_WIDTH{1'b0}}, h};
            push_last = 1'b1;
            h_v_n     = 1'b0;
            state_n   = DRAIN;
          end else begin
            state_n = FLUSH;
          end
        end else begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (count == {CW{1'b0}}) begin
          state_n = DONE;
        end else begin
          state_n = DRAIN;
        end
      end
      DONE: begin
        h_n     = {LANE_WIDTH{1'b0}};
        h_v_n   = 1'b0;
        s_n     = {WW{1'b0}};
        s_v_n   = 1'b0;
        state_n = RUN;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  // State, holding registers and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      h      <= {LANE_WIDTH{1'b0}};
      h_v    <= 1'b0;
      s      <= {WW{1'b0}};
      s_v    <= 1'b0;
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      state  <= state_n;
      h      <= h_n;
      h_v    <= h_v_n;
      s      <= s_n;
      s_v    <= s_v_n;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {push_last, push_word};
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

`ifdef WB_PACK_ELEM_CNT_EN
  // Per-frame element count; frozen once the frame stops accepting input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_elems <= 32'd0;
    end else if (state == DONE) begin
      frame_elems <= 32'd0;
    end else if (accept) begin
      frame_elems <= frame_elems + 32'(in_valid0) + 32'(in_valid1);
    end else begin
      frame_elems <= frame_elems;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stream_packer.sv
// Directed self-checking bench for wb_stream_packer.
module tb_wb_stream_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [24:0] in_data0 = 25'd0;
  logic        in_valid0 = 1'b0;
  logic [24:0] in_data1 = 25'd0;
  logic        in_valid1 = 1'b0;
  logic        end_op = 1'b0;
  logic        stall;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b0;
  logic        frame_done;
  logic        busy;
`ifdef WB_PACK_ELEM_CNT_EN
  logic [31:0] frame_elems;
`endif

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [63:0] got_data[$];
  logic        got_last[$];

  wb_stream_packer dut (
    .clk(clk), .rst_n(rst_n),
    .in_data0(in_data0), .in_valid0(in_valid0),
    .in_data1(in_data1), .in_valid1(in_valid1),
    .end_op(end_op), .stall(stall),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
`ifdef WB_PACK_ELEM_CNT_EN
    .frame_elems(frame_elems),
`endif
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change only #1 after posedge, so negedge values hold through the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic send(input logic v0, input logic [24:0] d0, input logic v1,
                      input logic [24:0] d1, input logic eop);
    logic st;
    int guard;
    in_valid0 = v0; in_data0 = d0; in_valid1 = v1; in_data1 = d1; end_op = eop;
    guard = 0;
    do begin
      st = stall;
      @(posedge clk); #1;
      guard++;
    end while (st && guard < 300);
    if (st) begin
      errors++;
      $display("FAIL send_timeout: stall=%b required 0 within 300 cycles", st);
    end
    in_valid0 = 1'b0; in_valid1 = 1'b0; end_op = 1'b0;
  endtask

  task automatic wait_frame_done(input int start);
    for (int i = 0; i < 300 && fd_cnt == start; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (fd_cnt !== start + 1) begin
      errors++;
      $display("FAIL frame_done_pulses: got %0d required 1", fd_cnt - start);
    end
  endtask

  task automatic check_words(input string name, input logic [63:0] exp_d[$], input logic exp_l[$]);
    checks++;
    if (got_data.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d words required %0d", name, got_data.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL %s_word%0d: got %h last=%b required %h last=%b",
                 name, i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({stall, m_valid, m_last, frame_done, busy} !== 5'b0 || m_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b vld=%b last=%b fd=%b busy=%b data=%h required all 0",
               stall, m_valid, m_last, frame_done, busy, m_data);
    end
  endtask

  task automatic test_pairs();
    logic [63:0] ed[$];
    logic        el[$];
    int s0;
    got_data.delete(); got_last.delete();
    m_ready = 1'b1;
    s0 = fd_cnt;
    send(1'b1, 25'd1, 1'b1, 25'h1FFFFFF, 1'b0);
    send(1'b1, 25'd2, 1'b1, 25'h1FFFFFE, 1'b0);
    send(1'b1, 25'd3, 1'b1, 25'h1FFFFFD, 1'b0);
    send(1'b0, 25'd0, 1'b0, 25'd0, 1'b1);
    wait_frame_done(s0);
    ed = '{64'hFFFFFFFF_00000001, 64'hFFFFFFFE_00000002, 64'hFFFFFFFD_00000003};
    el = '{1'b0, 1'b0, 1'b1};
    check_words("pairs", ed, el);
  endtask

  task automatic test_odd();
    logic [63:0] ed[$];
    logic        el[$];
    int s0;
    got_data.delete(); got_last.delete();
    m_ready = 1'b1;
    s0 = fd_cnt;
    send(1'b1, 25'd5, 1'b0, 25'd0, 1'b0);
    send(1'b1, 25'd6, 1'b1, 25'd7, 1'b0);
    send(1'b0, 25'd0, 1'b0, 25'd0, 1'b1);
`ifdef WB_PACK_ELEM_CNT_EN
    checks++;
    if (frame_elems !== 32'd3) begin
      errors++;
      $display("FAIL odd_frame_elems: got %0d required 3", frame_elems);
    end
`endif
    wait_frame_done(s0);
    ed = '{64'h00000006_00000005, 64'h00000000_00000007};
    el = '{1'b0, 1'b1};
    check_words("odd", ed, el);
  endtask

  task automatic test_backpressure();
    logic [63:0] ed[$];
    logic        el[$];
    logic [24:0] a, b;
    int s0;
    got_data.delete(); got_last.delete();
    m_ready = 1'b0;
    s0 = fd_cnt;
    for (int k = 1; k <= 9; k++) begin
      a = 25'(k * 16);
      b = 25'(-k);
      send(1'b1, a, 1'b1, b, 1'b0);
      ed.push_back({32'(-k), 32'(k * 16)});
      el.push_back(k == 9);
      if (k == 8) begin
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall_at7: got %b required 0", stall);
        end
      end
    end
    checks++;
    if (stall !== 1'b1 || m_valid !== 1'b1 || m_data !== 64'hFFFFFFFF_00000010) begin
      errors++;
      $display("FAIL bp_full: got stall=%b vld=%b data=%h required 1 1 ffffffff00000010",
               stall, m_valid, m_data);
    end
    in_valid0 = 1'b1; in_data0 = 25'h0ABCDE; in_valid1 = 1'b1; in_data1 = 25'h0123;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (stall !== 1'b1 || m_data !== 64'hFFFFFFFF_00000010) begin
      errors++;
      $display("FAIL bp_hold: got stall=%b data=%h required 1 ffffffff00000010", stall, m_data);
    end
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    m_ready = 1'b1;
    send(1'b0, 25'd0, 1'b0, 25'd0, 1'b1);
    wait_frame_done(s0);
    check_words("bp", ed, el);
  endtask

  task automatic test_empty();
    int s0;
    got_data.delete(); got_last.delete();
    m_ready = 1'b1;
    s0 = fd_cnt;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL empty_pre_stall: got %b required 0", stall);
    end
    send(1'b0, 25'd0, 1'b0, 25'd0, 1'b1);
    checks++;
    if (stall !== 1'b1 || frame_done !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: got stall=%b fd=%b vld=%b required 1 1 0", stall, frame_done, m_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (stall !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: got stall=%b fd=%b busy=%b required 0 0 0", stall, frame_done, busy);
    end
    wait_frame_done(s0);
    checks++;
    if (got_data.size() !== 0) begin
      errors++;
      $display("FAIL empty_words: got %0d words required 0", got_data.size());
    end
  endtask

  task automatic test_negative();
    logic [63:0] ed[$];
    logic        el[$];
    int s0;
    got_data.delete(); got_last.delete();
    m_ready = 1'b1;
    s0 = fd_cnt;
    send(1'b1, 25'h1000000, 1'b0, 25'd0, 1'b0);
    send(1'b0, 25'd0, 1'b0, 25'd0, 1'b1);
    wait_frame_done(s0);
    ed = '{64'h00000000_FF000000};
    el = '{1'b1};
    check_words("neg", ed, el);
  endtask

  task automatic test_reset_mid();
    logic [63:0] ed[$];
    logic        el[$];
    int s0;
    got_data.delete(); got_last.delete();
    m_ready = 1'b0;
    send(1'b1, 25'd1, 1'b1, 25'd2, 1'b0);
    send(1'b1, 25'd3, 1'b1, 25'd4, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got vld=%b busy=%b required 1 1", m_valid, busy);
    end
    s0 = fd_cnt;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({stall, m_valid, m_last, frame_done, busy} !== 5'b0 || m_data !== 64'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got stall=%b vld=%b last=%b fd=%b busy=%b data=%h required all 0",
               stall, m_valid, m_last, frame_done, busy, m_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_data.delete(); got_last.delete();
    m_ready = 1'b1;
    send(1'b1, 25'd10, 1'b1, 25'd20, 1'b0);
    send(1'b0, 25'd0, 1'b0, 25'd0, 1'b1);
    wait_frame_done(s0);
    ed = '{64'h00000014_0000000A};
    el = '{1'b1};
    check_words("rstmid", ed, el);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_pairs();
    test_odd();
    test_backpressure();
    test_empty();
    test_negative();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
